// File: rtl/exec_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding, load-use stall, multi-cycle ALU stall, branch flush.
// Optional performance counters are enabled with the EXEC_HAZARD_PERF_EN macro.
module exec_hazard_ctrl #(
  parameter int unsigned MC_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] RS1_D,
  input  logic [3:0] RS2_D,
  input  logic       use1_D,
  input  logic       use2_D,
  input  logic [3:0] RS1_E,
  input  logic [3:0] RS2_E,
  input  logic [3:0] RD_E,
  input  logic       isWb_E,
  input  logic       isLd_E,
  input  logic [3:0] RD_M,
  input  logic [3:0] RD_W,
  input  logic       isWb_M,
  input  logic       isWb_W,
  input  logic       isbranchtaken_E,
  input  logic       mc_start_E,
  output logic [1:0] forwardA_E,
  output logic [1:0] forwardB_E,
  output logic       stall_F,
  output logic       stall_D,
  output logic       stall_E,
  output logic       flush_D,
  output logic       flush_E,
`ifdef EXEC_HAZARD_PERF_EN
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt,
`endif
  output logic       mc_done
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, LDUSE, MC_BUSY, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_use;
  logic             sf, sd, se, fd, fe, done;

  // Memory-stage result is younger, so it wins over writeback.
  always_comb begin
    forwardA_E = 2'b00;
    forwardB_E = 2'b00;
    if (isWb_M && RD_M == RS1_E)      forwardA_E = 2'b10;
    else if (isWb_W && RD_W == RS1_E) forwardA_E = 2'b01;
    if (isWb_M && RD_M == RS2_E)      forwardB_E = 2'b10;
    else if (isWb_W && RD_W == RS2_E) forwardB_E = 2'b01;
  end

  assign load_use = isLd_E & isWb_E &
                    ((use1_D & (RD_E == RS1_D)) | (use2_D & (RD_E == RS2_D)));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sf        = 1'b0;
    sd        = 1'b0;
    se        = 1'b0;
    fd        = 1'b0;
    fe        = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (isbranchtaken_E) begin
          fd        = 1'b1;
          fe        = 1'b1;
          state_nxt = FLUSH;
        end else if (mc_start_E) begin
          cnt_nxt   = CNT_W'(MC_LAT - 1);
          sf        = 1'b1;
          sd        = 1'b1;
          se        = 1'b1;
          state_nxt = MC_BUSY;
        end else if (load_use) begin
          sf        = 1'b1;
          sd        = 1'b1;
          fe        = 1'b1;
          state_nxt = LDUSE;
        end
      end
      LDUSE: begin
        if (isbranchtaken_E) begin
          fd        = 1'b1;
          fe        = 1'b1;
          state_nxt = FLUSH;
        end else begin
          state_nxt = IDLE;
        end
      end
      MC_BUSY: begin
        // The start cycle counts as the first execute cycle, so finish when the decrement hits zero.
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt_nxt == '0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          sf = 1'b1;
          sd = 1'b1;
          se = 1'b1;
        end
      end
      FLUSH: begin
        fd        = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  // Reset silences control outputs; a flushed stage is never also stalled.
  always_comb begin
    stall_F = sf & rst;
    stall_D = sd & rst & ~fd;
    stall_E = se & rst & ~fe;
    flush_D = fd & rst;
    flush_E = fe & rst;
    mc_done = done & rst;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef EXEC_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_D && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (state_nxt == FLUSH && state != FLUSH && flush_cnt != '1) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Directed vector bench for exec_hazard_ctrl (MC_LAT = 4).
module tb_exec_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] RS1_D = '0, RS2_D = '0, RS1_E = '0, RS2_E = '0, RD_E = '0, RD_M = '0, RD_W = '0;
  logic       use1_D = 0, use2_D = 0, isWb_E = 0, isLd_E = 0, isWb_M = 0, isWb_W = 0;
  logic       isbranchtaken_E = 0, mc_start_E = 0;
  logic [1:0] forwardA_E, forwardB_E;
  logic       stall_F, stall_D, stall_E, flush_D, flush_E, mc_done;
`ifdef EXEC_HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exec_hazard_ctrl #(.MC_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .use1_D(use1_D), .use2_D(use2_D),
    .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E), .isWb_E(isWb_E), .isLd_E(isLd_E),
    .RD_M(RD_M), .RD_W(RD_W), .isWb_M(isWb_M), .isWb_W(isWb_W),
    .isbranchtaken_E(isbranchtaken_E), .mc_start_E(mc_start_E),
    .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
    .flush_D(flush_D), .flush_E(flush_E),
`ifdef EXEC_HAZARD_PERF_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .mc_done(mc_done)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] rs1_d, rs2_d;
    logic       use1, use2;
    logic [3:0] rs1_e, rs2_e, rd_e;
    logic       wb_e, ld_e;
    logic [3:0] rd_m, rd_w;
    logic       wb_m, wb_w, br, mc;
    logic [1:0] fa, fb;
    logic [5:0] ctl;   // {stall_F, stall_D, stall_E, flush_D, flush_E, mc_done}
  } vec_t;

  vec_t tbl[$];
  vec_t cur;

  function automatic vec_t blank(string name, logic r);
    vec_t v;
    v.name = name; v.rst = r;
    v.rs1_d = 0; v.rs2_d = 0; v.use1 = 0; v.use2 = 0;
    v.rs1_e = 0; v.rs2_e = 0; v.rd_e = 0; v.wb_e = 0; v.ld_e = 0;
    v.rd_m = 0; v.rd_w = 0; v.wb_m = 0; v.wb_w = 0; v.br = 0; v.mc = 0;
    v.fa = 2'b00; v.fb = 2'b00; v.ctl = 6'b000000;
    return v;
  endfunction

  // Load-use on RS2_D via a load writing r7.
  function automatic vec_t ldu(string name, logic br, logic mc, logic [5:0] ctl);
    vec_t v;
    v = blank(name, 1'b1);
    v.ld_e = 1; v.wb_e = 1; v.rd_e = 4'd7; v.rs2_d = 4'd7; v.use2 = 1;
    v.br = br; v.mc = mc; v.ctl = ctl;
    return v;
  endfunction

  function automatic vec_t ctl_only(string name, logic br, logic mc, logic [5:0] ctl);
    vec_t v;
    v = blank(name, 1'b1);
    v.br = br; v.mc = mc; v.ctl = ctl;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst = v.rst; RS1_D = v.rs1_d; RS2_D = v.rs2_d; use1_D = v.use1; use2_D = v.use2;
    RS1_E = v.rs1_e; RS2_E = v.rs2_e; RD_E = v.rd_e; isWb_E = v.wb_e; isLd_E = v.ld_e;
    RD_M = v.rd_m; RD_W = v.rd_w; isWb_M = v.wb_m; isWb_W = v.wb_w;
    isbranchtaken_E = v.br; mc_start_E = v.mc;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] ctl_now();
    return {stall_F, stall_D, stall_E, flush_D, flush_E, mc_done};
  endfunction

  initial begin
    vec_t v;
    int n_stall, done_at;
    logic got_done;

    // Forwarding during reset, with control requests that must be ignored.
    v = blank("rst_fwd", 1'b0);
    v.rd_m = 3; v.wb_m = 1; v.rd_w = 3; v.wb_w = 1; v.rs1_e = 3; v.rs2_e = 5;
    v.br = 1; v.mc = 1; v.fa = 2'b10; v.fb = 2'b00; tbl.push_back(v);
    v = blank("fwd_m_w", 1'b1);
    v.rd_m = 2; v.wb_m = 1; v.rs1_e = 2; v.rd_w = 5; v.wb_w = 1; v.rs2_e = 5;
    v.fa = 2'b10; v.fb = 2'b01; tbl.push_back(v);
    v = blank("fwd_m_nowb", 1'b1);
    v.rd_m = 4; v.wb_m = 0; v.rd_w = 4; v.wb_w = 1; v.rs1_e = 4; v.rs2_e = 4;
    v.fa = 2'b01; v.fb = 2'b01; tbl.push_back(v);
    v = blank("fwd_none", 1'b1);
    v.rd_m = 6; v.wb_m = 0; v.rd_w = 6; v.wb_w = 0; v.rs1_e = 6; v.rs2_e = 9;
    tbl.push_back(v);
    tbl.push_back(ldu("ldu_hit", 0, 0, 6'b110010));
    tbl.push_back(ldu("ldu_hold", 0, 0, 6'b000000));
    v = ldu("ldu_nouse", 0, 0, 6'b000000); v.use2 = 0; tbl.push_back(v);
    v = ldu("ldu_nowb", 0, 0, 6'b000000); v.wb_e = 0; tbl.push_back(v);
    v = ldu("ldu_rs1", 0, 0, 6'b110010); v.use2 = 0; v.use1 = 1; v.rs1_d = 7; tbl.push_back(v);
    tbl.push_back(ctl_only("ldu_after", 0, 0, 6'b000000));
    tbl.push_back(ctl_only("mc_start", 0, 1, 6'b111000));
    tbl.push_back(ctl_only("mc_busy_br", 1, 0, 6'b111000));
    tbl.push_back(ldu("mc_busy_ldu", 0, 0, 6'b111000));
    tbl.push_back(ctl_only("mc_done", 1, 0, 6'b000001));
    tbl.push_back(ldu("br_ldu", 1, 0, 6'b000110));
    tbl.push_back(ldu("flush_ldu", 0, 0, 6'b000100));
    tbl.push_back(ctl_only("flush_idle", 0, 0, 6'b000000));
    tbl.push_back(ldu("ldu2", 0, 0, 6'b110010));
    tbl.push_back(ctl_only("ldu_br", 1, 0, 6'b000110));
    tbl.push_back(ctl_only("flush2", 0, 0, 6'b000100));
    tbl.push_back(ctl_only("br_vs_mc", 1, 1, 6'b000110));
    tbl.push_back(ctl_only("flush_mc", 0, 1, 6'b000100));
    tbl.push_back(ldu("mc_vs_ldu", 0, 1, 6'b111000));
    tbl.push_back(ctl_only("busy1", 0, 0, 6'b111000));
    tbl.push_back(blank("rst_busy2", 1'b0));
    tbl.push_back(ctl_only("after_rst", 0, 0, 6'b000000));
    tbl.push_back(ctl_only("idle_again", 0, 0, 6'b000000));

    rst = 1'b0;
    foreach (tbl[i]) begin
      cur = tbl[i];
      @(negedge clk);
      apply(cur);
      #1;
      chk({cur.name, ".fa"}, 32'(forwardA_E), 32'(cur.fa));
      chk({cur.name, ".fb"}, 32'(forwardB_E), 32'(cur.fb));
      chk({cur.name, ".ctl"}, 32'(ctl_now()), 32'(cur.ctl));
    end

    // Multi-cycle latency from an mc_start_E pulse, branch held high throughout.
    n_stall = 0; done_at = 0; got_done = 1'b0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      @(negedge clk);
      v = ctl_only("lat", c != 0, c == 0, 6'b0);
      apply(v);
      #1;
      if (c != 0 && (flush_D || flush_E)) chk("lat_noflush", 32'(ctl_now()), 32'(6'b111000));
      if (stall_E) n_stall++;
      if (mc_done) begin got_done = 1'b1; done_at = c + 1; end
    end
    chk("lat_stall_cycles", 32'(n_stall), 32'd3);
    chk("lat_done_cycle", 32'(done_at), 32'd4);
    @(negedge clk);
    apply(ctl_only("lat_idle", 0, 0, 6'b0));
    #1;
    chk("lat_idle_ctl", 32'(ctl_now()), 32'd0);

`ifdef EXEC_HAZARD_PERF_EN
    @(negedge clk); apply(blank("perf_rst", 1'b0));
    @(negedge clk); apply(ldu("p1", 0, 0, 6'b0));
    @(negedge clk); apply(ctl_only("p2", 0, 0, 6'b0));
    @(negedge clk); apply(ldu("p3", 0, 0, 6'b0));
    @(negedge clk); apply(ctl_only("p4", 0, 0, 6'b0));
    @(negedge clk); apply(ctl_only("p5", 1, 0, 6'b0));
    @(negedge clk); apply(ctl_only("p6", 0, 0, 6'b0));
    @(negedge clk); apply(ctl_only("p7", 0, 0, 6'b0));
    #1;
    chk("perf_stall_cnt", stall_cnt, 32'd2);
    chk("perf_flush_cnt", 32'(flush_cnt), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_hazard_ctrl.md
EXEC_HAZARD_CTRL -- requirements
Module: exec_hazard_ctrl

Interface
REQ-001 SHALL have parameter MC_LAT, default 4, meaning total execute-stage cycles of a multi-cycle ALU op (legal range 2..15).
REQ-002 SHALL have ports clk in 1 (system clock) and rst in 1 (reset).
REQ-003 clk and rst: one clock; rst is synchronous, active-low.
REQ-004 RS1_D, RS2_D in 4 each: decode-stage source registers; use1_D, use2_D in 1 each: the source is actually read.
REQ-005 RS1_E, RS2_E, RD_E in 4 each; isWb_E, isLd_E in 1 each: execute-stage operands, destination, writeback flag and load flag.
REQ-006 RD_M, RD_W in 4 each; isWb_M, isWb_W in 1 each: memory- and writeback-stage destinations and write flags.
REQ-007 isbranchtaken_E in 1: branch resolved taken in execute.
REQ-008 mc_start_E in 1: execute holds a multi-cycle ALU op.
REQ-009 forwardA_E, forwardB_E out 2 each: operand selects, 00 register file, 01 writeback data (data_RW_E), 10 memory data (data_M_E); 11 is never driven.
REQ-010 stall_F, stall_D, stall_E out 1 each: hold the fetch, decode and execute pipeline registers.
REQ-011 flush_D, flush_E out 1 each: load a NOP into the D or E pipeline register.
REQ-012 mc_done out 1: single-cycle pulse on the final cycle of a multi-cycle op.

Function
REQ-013 Forwarding SHALL be combinational: forwardA_E = 10 if isWb_M and RD_M == RS1_E; else 01 if isWb_W and RD_W == RS1_E; else 00. forwardB_E uses RS2_E by the same rule.
REQ-014 The memory-stage match SHALL take priority over the writeback-stage match when both hit.
REQ-015 The FSM SHALL have the states IDLE, LDUSE, MC_BUSY and FLUSH.
REQ-016 Load-use in IDLE is isLd_E & isWb_E & ((use1_D & RD_E == RS1_D) | (use2_D & RD_E == RS2_D)).
REQ-017 On load-use, stall_F, stall_D and flush_E SHALL assert in that cycle and the FSM SHALL go to LDUSE.
REQ-018 LDUSE SHALL last exactly 1 cycle, with all outputs deasserted except forwarding, then return to IDLE.
REQ-019 In IDLE, mc_start_E SHALL load the 4-bit counter with MC_LAT-1, go to MC_BUSY, and assert stall_F, stall_D and stall_E in that same cycle.
REQ-020 In MC_BUSY the counter SHALL decrement by 1 each cycle, with stalls held while counter != 0.
REQ-021 At counter == 0, mc_done = 1, the stalls are released and the FSM returns to IDLE; total stall = MC_LAT-1 cycles.
REQ-022 In IDLE or LDUSE, isbranchtaken_E SHALL assert flush_D and flush_E that cycle, clear any stall, and go to FLUSH.
REQ-023 FLUSH SHALL assert flush_D for 1 more cycle, then go to IDLE.
REQ-024 Priority in IDLE SHALL be: branch taken > mc_start_E > load-use.
REQ-025 isbranchtaken_E SHALL be ignored in MC_BUSY and load-use detection SHALL be suppressed in MC_BUSY and FLUSH.
REQ-026 A stage SHALL never see stall and flush together; flush wins.

Reset
REQ-027 While rst == 0 at a clk edge: FSM to IDLE, counter to 0, all stall/flush outputs and mc_done to 0.
REQ-028 Forward selects follow REQ-013 during reset.
REQ-029 Reset during MC_BUSY or FLUSH SHALL abort the operation with no mc_done pulse.
REQ-030 The first cycle after rst releases SHALL behave as IDLE.

Configuration
REQ-031 Macro EXEC_HAZARD_PERF_EN defined: add outputs stall_cnt out 32 (cycles with stall_D = 1) and flush_cnt out 16 (FLUSH entries).
REQ-032 The counters SHALL saturate at all-ones and clear on reset.
REQ-033 EXEC_HAZARD_PERF_EN undefined: the ports and counters are absent and behaviour is otherwise identical.

Verification
REQ-034 RD_M=3, isWb_M=1, RD_W=3, isWb_W=1, RS1_E=3, RS2_E=5 -> forwardA_E=10, forwardB_E=00.
REQ-035 isLd_E=1, isWb_E=1, RD_E=7, RS2_D=7, use2_D=1 -> stall_F=stall_D=flush_E=1 for exactly 1 cycle, then all 0.
REQ-036 MC_LAT=4, mc_start_E pulse -> stall_E=1 for 3 cycles, mc_done=1 on the 4th cycle, and a branch taken during that window produces no flush.
REQ-037 isbranchtaken_E with a simultaneous load-use -> flush_D=flush_E=1 and stall_D=0 in the first cycle, flush_D=1 in the next cycle, then IDLE.
REQ-038 rst=0 asserted on the 2nd MC_BUSY cycle -> next cycle all stalls 0, no mc_done pulse, FSM in IDLE.
REQ-039 With EXEC_HAZARD_PERF_EN: 2 load-use stalls plus 1 branch -> stall_cnt=2, flush_cnt=1.
